// File: rtl/d_stage_pkg.sv
// Shared decode-stage constants: RV32 opcodes, immediate-select encoding, canonical NOP.
package d_stage_pkg;

    localparam int unsigned OPC_W     = 7;
    localparam int unsigned IMM_SEL_W = 3;
    localparam int unsigned KCNT_W    = 3;

    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b000_0011;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b010_0011;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b110_0011;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b110_1111;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b110_0111;
    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b011_0111;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b001_0111;
    localparam logic [OPC_W-1:0] OPC_ARI_ITYPE = 7'b001_0011;
    localparam logic [OPC_W-1:0] OPC_ARI_RTYPE = 7'b011_0011;
    localparam logic [OPC_W-1:0] OPC_CSR       = 7'b111_0011;

    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_S     = 3'd0,
        IMM_B     = 3'd1,
        IMM_U     = 3'd2,
        IMM_J     = 3'd3,
        IMM_I     = 3'd4,
        IMM_SHAMT = 3'd5,
        IMM_CSR   = 3'd6,
        IMM_NONE  = 3'd7
    } imm_sel_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] inst);
        return inst[OPC_W-1:0];
    endfunction

endpackage

// File: rtl/d_inst_decode.sv
// Combinational D-stage decode: immediate type, register-use flags and raw rs1/rs2 fields.
module d_inst_decode
    import d_stage_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [XLEN-1:0]      i_inst,
    output logic [IMM_SEL_W-1:0] o_imm_sel,
    output logic                 o_rs1_used,
    output logic                 o_rs2_used,
    output logic [REG_AW-1:0]    o_rs1,
    output logic [REG_AW-1:0]    o_rs2
);

    imm_sel_e         w_imm_sel;
    logic [OPC_W-1:0] w_opc;
    logic [2:0]       w_funct3;
    logic             w_unused_bits;

    assign w_opc         = opcode_of(32'(i_inst));
    assign w_funct3      = i_inst[14:12];
    assign o_rs1         = REG_AW'(i_inst[19:15]);
    assign o_rs2         = REG_AW'(i_inst[24:20]);
    assign w_unused_bits = ^{i_inst[XLEN-1:25], i_inst[11:7]};

    always_comb begin
        w_imm_sel  = IMM_NONE;
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b0;
        case (w_opc)
            OPC_STORE: begin
                w_imm_sel  = IMM_S;
                o_rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm_sel  = IMM_B;
                o_rs2_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm_sel  = IMM_U;
                o_rs1_used = 1'b0;
            end
            OPC_JAL: begin
                w_imm_sel  = IMM_J;
                o_rs1_used = 1'b0;
            end
            OPC_LOAD, OPC_JALR: w_imm_sel = IMM_I;
            // Shift-immediates carry shamt in the immediate field
            OPC_ARI_ITYPE: w_imm_sel = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
            OPC_CSR: begin
                w_imm_sel  = IMM_CSR;
                o_rs1_used = ~w_funct3[2];
            end
            OPC_ARI_RTYPE: begin
                w_imm_sel  = IMM_NONE;
                o_rs2_used = 1'b1;
            end
            default: w_imm_sel = IMM_NONE;
        endcase
    end

    assign o_imm_sel = w_imm_sel;

endmodule

// File: rtl/d_stage_ctrl.sv
// D-stage controller: instruction register, post-redirect squash window, load-use interlock.
// Optional interlock enabled by defining LOAD_USE_INTERLOCK_EN; otherwise stall is tied low.
module d_stage_ctrl
    import d_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned KILL_SLOTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      f_inst,
    input  logic                 f_valid,
    input  logic [XLEN-1:0]      x_inst,
    input  logic                 x_valid,
    input  logic                 x_redirect,
    output logic [XLEN-1:0]      d_inst,
    output logic                 d_valid,
    output logic [IMM_SEL_W-1:0] imm_sel,
    output logic [REG_AW-1:0]    rs1_addr,
    output logic [REG_AW-1:0]    rs2_addr,
    output logic                 icache_re,
    output logic                 stall,
    output logic                 d_to_x_valid
);

    localparam logic [KCNT_W-1:0] KILL_RELOAD = KCNT_W'(KILL_SLOTS - 1);

    logic [XLEN-1:0]   r_d_inst;
    logic              r_d_valid;
    logic [KCNT_W-1:0] r_kill_cnt;

    logic              w_rs1_used;
    logic              w_rs2_used;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic              w_stall;

    d_inst_decode #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_decode (
        .i_inst     (r_d_inst),
        .o_imm_sel  (imm_sel),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used),
        .o_rs1      (w_rs1),
        .o_rs2      (w_rs2)
    );

`ifdef LOAD_USE_INTERLOCK_EN
    logic              w_x_load;
    logic [REG_AW-1:0] w_x_rd;
    logic              w_rs1_hit;
    logic              w_rs2_hit;
    logic              w_unused_x;

    assign w_x_load   = (x_inst[OPC_W-1:0] == OPC_LOAD);
    assign w_x_rd     = REG_AW'(x_inst[11:7]);
    assign w_rs1_hit  = w_rs1_used & (w_x_rd == w_rs1);
    assign w_rs2_hit  = w_rs2_used & (w_x_rd == w_rs2);
    assign w_unused_x = ^x_inst[XLEN-1:12];
    // A redirect squashes D anyway, so it overrides the interlock
    assign w_stall    = r_d_valid & x_valid & w_x_load & (w_x_rd != '0)
                      & (w_rs1_hit | w_rs2_hit) & ~x_redirect;
`else
    logic w_unused_x;

    assign w_unused_x = ^{x_inst, x_valid};
    assign w_stall    = 1'b0;
`endif

    // D register update: redirect, then squash window, then stall hold, then fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_inst   <= XLEN'(INST_NOP);
            r_d_valid  <= 1'b0;
            r_kill_cnt <= '0;
        end else if (x_redirect) begin
            r_d_inst   <= XLEN'(INST_NOP);
            r_d_valid  <= 1'b0;
            r_kill_cnt <= KILL_RELOAD;
        end else if (r_kill_cnt != '0) begin
            r_d_inst   <= XLEN'(INST_NOP);
            r_d_valid  <= 1'b0;
            r_kill_cnt <= r_kill_cnt - KCNT_W'(1);
        end else if (!w_stall) begin
            r_d_inst   <= f_inst;
            r_d_valid  <= f_valid;
        end
    end

    assign d_inst       = r_d_inst;
    assign d_valid      = r_d_valid;
    assign rs1_addr     = (r_d_valid & w_rs1_used) ? w_rs1 : '0;
    assign rs2_addr     = (r_d_valid & w_rs2_used) ? w_rs2 : '0;
    assign stall        = w_stall;
    assign icache_re    = ~w_stall;
    assign d_to_x_valid = r_d_valid & ~w_stall & ~x_redirect;

endmodule
